// File: rtl/dsram_req_ctrl_if.sv
// dsram_req_ctrl_if: MEM1 request, SRAM bus, flush and MEM2 response signals.
interface dsram_req_ctrl_if #(parameter int TAG_W = 4);
    logic             m1s_req_valid;
    logic             m1s_req_wr;
    logic [TAG_W-1:0] m1s_req_tag;
    logic             m1s_req_stall;
    logic             data_sram_req;
    logic             data_sram_addr_ok;
    logic             data_sram_data_ok;
    logic [31:0]      data_sram_rdata;
    logic             ws_flush;
    logic             m2s_data_ok;
    logic [31:0]      m2s_rdata;
    logic [TAG_W-1:0] m2s_data_tag;
    logic             m2s_data_wr;
    logic             m2s_pending;
    logic             req_full;
    logic             req_empty;
    logic             proto_err;
    modport slave (
        input  m1s_req_valid, m1s_req_wr, m1s_req_tag, data_sram_addr_ok,
               data_sram_data_ok, data_sram_rdata, ws_flush,
        output m1s_req_stall, data_sram_req, m2s_data_ok, m2s_rdata, m2s_data_tag,
               m2s_data_wr, m2s_pending, req_full, req_empty, proto_err
    );
    modport master (
        output m1s_req_valid, m1s_req_wr, m1s_req_tag, data_sram_addr_ok,
               data_sram_data_ok, data_sram_rdata, ws_flush,
        input  m1s_req_stall, data_sram_req, m2s_data_ok, m2s_rdata, m2s_data_tag,
               m2s_data_wr, m2s_pending, req_full, req_empty, proto_err
    );
endinterface

// File: rtl/dsram_req_ctrl.sv
// dsram_req_ctrl: in-order tracker of outstanding data-SRAM requests with flush cancellation.
module dsram_req_ctrl #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    dsram_req_ctrl_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d, live_cnt_q, live_cnt_d;
    logic             cancel_q [DEPTH];
    logic             cancel_d [DEPTH];
    logic             wr_q [DEPTH];
    logic             wr_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic             proto_err_q, proto_err_d;
    logic             full, empty, req, push, pop, deliver;
    always_comb begin
        full    = count_q == (PW+1)'(DEPTH);
        empty   = count_q == '0;
        req     = bus.m1s_req_valid && !full && !bus.ws_flush;
        push    = req && bus.data_sram_addr_ok;
        pop     = bus.data_sram_data_ok && !empty;
        // pop sees the pre-flush cancel bit so a live head is still delivered
        deliver = pop && !cancel_q[rd_ptr_q];
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
        live_cnt_d  = bus.ws_flush ? '0 : live_cnt_q + (PW+1)'(push) - (PW+1)'(deliver);
        proto_err_d = proto_err_q || (bus.data_sram_data_ok && empty);
        for (int i = 0; i < DEPTH; i++) begin
            cancel_d[i] = bus.ws_flush ? 1'b1 : (push && wr_ptr_q == PW'(i)) ? 1'b0 : cancel_q[i];
            wr_d[i]     = (push && wr_ptr_q == PW'(i)) ? bus.m1s_req_wr : wr_q[i];
            tag_d[i]    = (push && wr_ptr_q == PW'(i)) ? bus.m1s_req_tag : tag_q[i];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            live_cnt_q  <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                cancel_q[i] <= 1'b0;
                wr_q[i]     <= 1'b0;
                tag_q[i]    <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            live_cnt_q  <= live_cnt_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                cancel_q[i] <= cancel_d[i];
                wr_q[i]     <= wr_d[i];
                tag_q[i]    <= tag_d[i];
            end
        end
    end
    assign bus.data_sram_req = req;
    assign bus.m1s_req_stall = bus.m1s_req_valid && !push;
    assign bus.m2s_data_ok   = deliver;
    assign bus.m2s_rdata     = bus.data_sram_rdata;
    assign bus.m2s_data_tag  = tag_q[rd_ptr_q];
    assign bus.m2s_data_wr   = wr_q[rd_ptr_q];
    assign bus.m2s_pending   = live_cnt_q != '0;
    assign bus.req_full      = full;
    assign bus.req_empty     = empty;
    assign bus.proto_err     = proto_err_q;
endmodule

// File: tb/tb_dsram_req_ctrl.sv
// tb_dsram_req_ctrl: directed and random stimulus checked against a queue-based model.
module tb_dsram_req_ctrl;
    typedef struct {bit c; bit wr; logic [3:0] tag;} ent_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    ent_t q[$];
    bit perr = 1'b0;
    dsram_req_ctrl_if #(.TAG_W(4)) bus ();
    dsram_req_ctrl #(.DEPTH(2), .TAG_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask
    task automatic step(input bit v, input bit wr, input logic [3:0] tag,
                        input bit aok, input bit dok, input bit fl);
        bit exp_req, push, pop, del;
        int live;
        logic [31:0] rd;
        rd = $urandom;
        bus.m1s_req_valid = v;
        bus.m1s_req_wr = wr;
        bus.m1s_req_tag = tag;
        bus.data_sram_addr_ok = aok;
        bus.data_sram_data_ok = dok;
        bus.data_sram_rdata = rd;
        bus.ws_flush = fl;
        #1;
        live = 0;
        foreach (q[i]) if (!q[i].c) live++;
        exp_req = v && q.size() < 2 && !fl;
        push = exp_req && aok;
        pop = dok && q.size() > 0;
        del = pop && !q[0].c;
        chk("req", 32'(bus.data_sram_req), 32'(exp_req));
        chk("stall", 32'(bus.m1s_req_stall), 32'(v && !push));
        chk("data_ok", 32'(bus.m2s_data_ok), 32'(del));
        chk("rdata", bus.m2s_rdata, rd);
        chk("full", 32'(bus.req_full), 32'(q.size() == 2));
        chk("empty", 32'(bus.req_empty), 32'(q.size() == 0));
        chk("pending", 32'(bus.m2s_pending), 32'(live != 0));
        chk("proto_err", 32'(bus.proto_err), 32'(perr));
        if (del) begin
            chk("tag", 32'(bus.m2s_data_tag), 32'(q[0].tag));
            chk("wr", 32'(bus.m2s_data_wr), 32'(q[0].wr));
        end
        @(posedge clk);
        if (dok && q.size() == 0) perr = 1'b1;
        if (pop) void'(q.pop_front());
        if (fl) foreach (q[i]) q[i].c = 1'b1;
        if (push) q.push_back('{1'b0, wr, tag});
        @(negedge clk);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        bus.m1s_req_valid = 0;
        bus.m1s_req_wr = 0;
        bus.m1s_req_tag = 0;
        bus.data_sram_addr_ok = 0;
        bus.data_sram_data_ok = 0;
        bus.data_sram_rdata = 0;
        bus.ws_flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        // single load
        step(1, 0, 4'h9, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(1);
        // back-to-back with the third blocked while full
        step(1, 0, 4'h1, 1, 0, 0);
        step(1, 1, 4'h2, 1, 0, 0);
        step(1, 0, 4'h3, 1, 0, 0);
        step(1, 0, 4'h3, 1, 1, 0);
        step(1, 0, 4'h3, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(1);
        // flush with two loads outstanding
        step(1, 0, 4'h4, 1, 0, 0);
        step(1, 0, 4'h5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(1);
        // flush coinciding with data_ok on a live head
        step(1, 1, 4'h6, 1, 0, 0);
        step(1, 0, 4'h7, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        idle(1);
        // push and pop in the same cycle at count 1
        step(1, 0, 4'ha, 1, 0, 0);
        step(1, 1, 4'hb, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(1);
        // data_ok on empty sets sticky proto_err; reset clears it
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        perr = 1'b0;
        idle(1);
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 4'($urandom),
                 bit'($urandom_range(0, 1)),
                 q.size() > 0 ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 30) == 0),
                 $urandom_range(0, 9) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
